// File: rtl/inst_encoder.sv
// RV32 instruction word packer: field bundle + immediate in, encoded word out through
// a 2-entry output buffer, with range/alignment checking and a saturating error counter.

package inst_encoder_pkg;
  localparam int unsigned INST_W = 32;
  localparam int unsigned FMT_W  = 3;

  localparam logic [FMT_W-1:0] IMM_I_TYPE = 3'd0;
  localparam logic [FMT_W-1:0] IMM_S_TYPE = 3'd1;
  localparam logic [FMT_W-1:0] IMM_B_TYPE = 3'd2;
  localparam logic [FMT_W-1:0] IMM_U_TYPE = 3'd3;
  localparam logic [FMT_W-1:0] IMM_JAL    = 3'd4;
  localparam logic [FMT_W-1:0] IMM_JALR   = 3'd5;
  localparam logic [FMT_W-1:0] IMM_CSR    = 3'd6;

  typedef struct packed {
    logic              err;
    logic [INST_W-1:0] inst;
  } enc_word_t;
endpackage

module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter bit          CHECK_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FMT_W-1:0]  in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [INST_W-1:0] in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic              out_err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_count
);

  logic      fits_12;
  logic      fits_13;
  logic      fits_21;
  logic      err_raw;
  enc_word_t new_word;

  // An immediate fits N signed bits when everything from bit N-1 upward is a sign copy.
  assign fits_12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits_13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits_21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  // Field packing and legality check per format
  always_comb begin
    new_word.inst = '0;
    err_raw       = 1'b0;
    case (in_fmt)
      IMM_I_TYPE, IMM_JALR: begin
        new_word.inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        err_raw       = ~fits_12;
      end
      IMM_S_TYPE: begin
        new_word.inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        err_raw       = ~fits_12;
      end
      IMM_B_TYPE: begin
        new_word.inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
        err_raw       = ~fits_13 | in_imm[0];
      end
      IMM_U_TYPE: begin
        new_word.inst = {in_imm[31:12], in_rd, in_opcode};
        err_raw       = |in_imm[11:0];
      end
      IMM_JAL: begin
        new_word.inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        err_raw       = ~fits_21 | in_imm[0];
      end
      default: begin
        new_word.inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        err_raw       = 1'b0;
      end
    endcase
    new_word.err = CHECK_EN & err_raw;
  end

  logic      push;
  logic      pop;
  enc_word_t tail_q;
  logic      tail_valid_q;
  enc_word_t head_d;
  enc_word_t tail_d;
  logic      head_valid_d;
  logic      tail_valid_d;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Head lives directly in the output registers; tail shifts forward on pop.
  always_comb begin
    head_d       = '{err: out_err, inst: out_inst};
    head_valid_d = out_valid;
    tail_d       = tail_q;
    tail_valid_d = tail_valid_q;
    if (pop) begin
      head_d       = tail_q;
      head_valid_d = tail_valid_q;
      tail_valid_d = 1'b0;
    end
    if (push) begin
      if (!head_valid_d) begin
        head_d       = new_word;
        head_valid_d = 1'b1;
      end else begin
        tail_d       = new_word;
        tail_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_inst     <= '0;
      out_err      <= 1'b0;
      tail_q       <= '0;
      tail_valid_q <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      out_valid    <= head_valid_d;
      out_inst     <= head_d.inst;
      out_err      <= head_d.err;
      tail_q       <= tail_d;
      tail_valid_q <= tail_valid_d;
      in_ready     <= ~tail_valid_d;
    end
  end

  // Saturating count of errored words handed to the consumer; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (pop && out_err && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed and randomized checks of inst_encoder packing, buffering, error counting and reset.

module tb_inst_encoder;
  import inst_encoder_pkg::*;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic        err_clr;
  logic [15:0] err_count;

  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [31:0] sat_out_inst;
  logic        sat_out_err;
  logic [2:0]  sat_err_count;

  int checks = 0;
  int errors = 0;

  vec_t vecs[16];

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
    .err_clr(err_clr), .err_count(err_count)
  );

  // Narrow counter copy so saturation is reachable in a few words
  inst_encoder #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_inst(sat_out_inst),
    .out_err(sat_out_err), .err_clr(err_clr), .err_count(sat_err_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] ei, input logic ee);
    vec_t v;
    v.fmt = fmt; v.opc = opc; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.exp_inst = ei; v.exp_err = ee;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_fmt = v.fmt; in_opcode = v.opc; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
  endtask

  // Golden model: range checks expressed as signed intervals
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic signed [31:0] s = v.imm;
    r.exp_err = 1'b0;
    case (v.fmt)
      IMM_I_TYPE, IMM_JALR: begin
        r.exp_inst = {v.imm[11:0], v.rs1, v.f3, v.rd, v.opc};
        r.exp_err  = (s < -2048) || (s > 2047);
      end
      IMM_S_TYPE: begin
        r.exp_inst = {v.imm[11:5], v.rs2, v.rs1, v.f3, v.imm[4:0], v.opc};
        r.exp_err  = (s < -2048) || (s > 2047);
      end
      IMM_B_TYPE: begin
        r.exp_inst = {v.imm[12], v.imm[10:5], v.rs2, v.rs1, v.f3, v.imm[4:1], v.imm[11], v.opc};
        r.exp_err  = (s < -4096) || (s > 4095) || v.imm[0];
      end
      IMM_U_TYPE: begin
        r.exp_inst = {v.imm[31:12], v.rd, v.opc};
        r.exp_err  = (v.imm[11:0] != 12'd0);
      end
      IMM_JAL: begin
        r.exp_inst = {v.imm[20], v.imm[10:1], v.imm[11], v.imm[19:12], v.rd, v.opc};
        r.exp_err  = (s < -1048576) || (s > 1048575) || v.imm[0];
      end
      default: r.exp_inst = {v.f7, v.rs2, v.rs1, v.f3, v.rd, v.opc};
    endcase
    return r;
  endfunction

  initial begin
    int   exp_cnt;
    vec_t v;
    logic [31:0] rnd;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;

    //              fmt         opc    rd    rs1   rs2   f3    f7     imm           inst          err
    vecs[0]  = mk(IMM_I_TYPE, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF10093, 1'b0);
    vecs[1]  = mk(IMM_S_TYPE, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'h00000008, 32'h00512423, 1'b0);
    vecs[2]  = mk(IMM_U_TYPE, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123451B7, 1'b0);
    vecs[3]  = mk(IMM_JAL,    7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h001000EF, 1'b0);
    vecs[4]  = mk(IMM_B_TYPE, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000003, 32'h00208163, 1'b1);
    vecs[5]  = mk(IMM_I_TYPE, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h80010093, 1'b1);
    vecs[6]  = mk(IMM_I_TYPE, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 32'h80010093, 1'b0);
    vecs[7]  = mk(3'd7,       7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, 32'h402081B3, 1'b0);
    vecs[8]  = mk(IMM_U_TYPE, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 32'h123451B7, 1'b1);
    vecs[9]  = mk(IMM_JAL,    7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFFDFF06F, 1'b0);
    vecs[10] = mk(IMM_JAL,    7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00100000, 32'h800000EF, 1'b1);
    vecs[11] = mk(IMM_B_TYPE, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFF8, 32'hFE208CE3, 1'b0);
    vecs[12] = mk(IMM_JALR,   7'h67, 5'd0, 5'd1, 5'd0, 3'd0, 7'h00, 32'h00000000, 32'h00008067, 1'b0);
    vecs[13] = mk(IMM_CSR,    7'h73, 5'd5, 5'd0, 5'd0, 3'd1, 7'h18, 32'hFFFFFFFF, 32'h300012F3, 1'b0);
    vecs[14] = mk(IMM_S_TYPE, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'hFFFFFFFF, 32'hFE512FA3, 1'b0);
    vecs[15] = mk(IMM_B_TYPE, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00001000, 32'h80208063, 1'b1);

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: one word at a time, visible the cycle after push, popped the cycle after
    exp_cnt = 0;
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_inst", i), out_inst, vecs[i].exp_inst);
      check($sformatf("vec%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
      if (vecs[i].exp_err) exp_cnt++;
      @(posedge clk); #1;
      check($sformatf("vec%0d_drain", i), 32'(out_valid), 32'd0);
      check($sformatf("vec%0d_errcnt", i), 32'(err_count), 32'(exp_cnt));
      check($sformatf("vec%0d_satcnt", i), 32'(sat_err_count), 32'((exp_cnt > 7) ? 7 : exp_cnt));
    end

    // Saturation of the narrow counter
    drive(vecs[4]);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    exp_cnt += 5;
    check("sat_wide_cnt", 32'(err_count), 32'(exp_cnt));
    check("sat_narrow_cnt", 32'(sat_err_count), 32'd7);

    // Clear has priority over a same-cycle errored pop
    drive(vecs[4]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("clr_pre_err", 32'(out_err), 32'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("clr_wide_cnt", 32'(err_count), 32'd0);
    check("clr_narrow_cnt", 32'(sat_err_count), 32'd0);
    check("clr_popped", 32'(out_valid), 32'd0);

    // Backpressure: third word stalls, then all three drain in order
    out_ready = 1'b0;
    drive(vecs[0]); in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_ready1", 32'(in_ready), 32'd1);
    check("bp_head1", out_inst, vecs[0].exp_inst);
    drive(vecs[1]);
    @(posedge clk); #1;
    check("bp_full", 32'(in_ready), 32'd0);
    check("bp_head2", out_inst, vecs[0].exp_inst);
    drive(vecs[2]);
    @(posedge clk); #1;
    check("bp_still_full", 32'(in_ready), 32'd0);
    check("bp_held", out_inst, vecs[0].exp_inst);
    check("bp_held_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_out2", out_inst, vecs[1].exp_inst);
    check("bp_ready_again", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_out3", out_inst, vecs[2].exp_inst);
    check("bp_out3_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("bp_empty", 32'(out_valid), 32'd0);

    // Random stream at full rate with an async reset pulse partway through
    for (int i = 0; i < 100; i++) begin
      v.fmt = 3'($urandom_range(0, 7));
      rnd = $urandom; v.opc = rnd[6:0]; v.rd = rnd[11:7]; v.rs1 = rnd[16:12];
      v.rs2 = rnd[21:17]; v.f3 = rnd[24:22]; v.f7 = rnd[31:25];
      case ($urandom_range(0, 2))
        0:       v.imm = $urandom;
        1:       v.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        default: v.imm = $urandom & 32'hFFFFF000;
      endcase
      v = model(v);
      drive(v);
      in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_inst !== v.exp_inst || out_err !== v.exp_err) begin
        errors++;
        $display("FAIL stream%0d: got v=%0b inst=0x%08h err=%0b expected v=1 inst=0x%08h err=%0b",
                 i, out_valid, out_inst, out_err, v.exp_inst, v.exp_err);
      end
      if (i == 60) begin
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd1);
        check("async_rst_cnt", 32'(err_count), 32'd0);
        @(negedge clk) rst_n = 1'b1;
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_drained", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
